// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse_gen_multi push-button event generator:
// edge-mode encodings and a counter-width helper.
package pulse_gen_pkg;

  localparam int MODE_RISE = 0;
  localparam int MODE_FALL = 1;
  localparam int MODE_BOTH = 2;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One button channel: arming, edge strobes, hold counter, long-press and auto-repeat.
// Optional counter debounce filter ahead of the edge logic when PULSE_GEN_DEBOUNCE_EN is defined.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int MODE          = MODE_RISE,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int DB_CYCLES     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out,
  output logic long_press,
  output logic held
);

  localparam int              HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || DB_CYCLES < 1 || REPEAT_CYCLES < 0) begin : g_param_check
    $error("pulse_gen_ch: HOLD_CYCLES must be >= 2, DB_CYCLES >= 1, REPEAT_CYCLES >= 0");
  end

  logic btn;

`ifdef PULSE_GEN_DEBOUNCE_EN
  localparam int DW = cnt_width(DB_CYCLES);

  logic          filt_q, filt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // Filtered level flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (btn_in != filt_q) begin
      if (db_cnt_q == DW'(DB_CYCLES - 1)) filt_d = btn_in;
      else                                db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q   <= btn_in;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn = filt_q;
`else
  assign btn = btn_in;
`endif

  logic          prev_q, prev_d;
  logic          armed_q, armed_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pulse_q, pulse_d;
  logic          long_press_q, long_press_d;
  logic          held_q, held_d;
  logic          active, rise, fall, edge_hit, rep_run, rep_wrap;

  always_comb begin
    active   = armed_q & btn;
    rise     = armed_q & btn & ~prev_q;
    fall     = armed_q & ~btn & prev_q;
    edge_hit = (MODE == MODE_RISE) ? rise :
               (MODE == MODE_FALL) ? fall : (rise | fall);

    prev_d  = btn;
    armed_d = armed_q | ~btn;

    hold_cnt_d = '0;
    if (active) hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

    // Repeat runs only once the hold counter has saturated, i.e. after long_press.
    rep_run      = active & (hold_cnt_q == HOLD_MAX);
    long_press_d = active & (hold_cnt_q == HOLD_LAST);
    held_d       = active;
    pulse_d      = edge_hit | rep_wrap;
  end

  if (REPEAT_CYCLES > 0) begin : g_repeat
    localparam int            RW       = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
      rep_cnt_d = '0;
      if (rep_run && rep_cnt_q != REP_LAST) rep_cnt_d = rep_cnt_q + 1'b1;
      rep_wrap  = rep_run & (rep_cnt_q == REP_LAST);
    end

    always_ff @(posedge clock) begin
      if (reset) rep_cnt_q <= '0;
      else       rep_cnt_q <= rep_cnt_d;
    end
  end else begin : g_no_repeat
    assign rep_wrap = 1'b0;
  end

  // A button pressed through reset starts disarmed and stays silent until released.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      prev_q       <= btn_in;
      armed_q      <= ~btn_in;
      hold_cnt_q   <= '0;
      pulse_q      <= 1'b0;
      long_press_q <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      hold_cnt_q   <= hold_cnt_d;
      pulse_q      <= pulse_d;
      long_press_q <= long_press_d;
      held_q       <= held_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign long_press = long_press_q;
  assign held       = held_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// N_CH independent push-button event generators (edge strobe, long-press, auto-repeat).
// Define PULSE_GEN_DEBOUNCE_EN to add a per-channel debounce filter.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int MODE          = MODE_RISE,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int DB_CYCLES     = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] held
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_gen_ch #(
      .MODE          (MODE),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .DB_CYCLES     (DB_CYCLES)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .btn_in     (btn_in[i]),
      .pulse_out  (pulse_out[i]),
      .long_press (long_press[i]),
      .held       (held[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Randomised self-checking bench for pulse_gen_multi: four instances (MODE 0/1/2 with
// repeat, MODE 0 without repeat) share one button bus and are compared against a press-length model.
module tb_pulse_gen_multi;

  localparam int HOLD = 8;
  localparam int DB   = 4;
  localparam int NI   = 4;
  localparam int MODE_CFG [NI] = '{0, 1, 2, 0};
  localparam int REP_CFG  [NI] = '{4, 4, 4, 0};

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] pulse_o [NI];
  logic [3:0] long_o  [NI];
  logic [3:0] held_o  [NI];

  always #5 clock = ~clock;

  pulse_gen_multi #(.N_CH(4), .MODE(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(4), .DB_CYCLES(DB)) dut0 (
    .clock(clock), .reset(reset), .btn_in(btn),
    .pulse_out(pulse_o[0]), .long_press(long_o[0]), .held(held_o[0]));
  pulse_gen_multi #(.N_CH(4), .MODE(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(4), .DB_CYCLES(DB)) dut1 (
    .clock(clock), .reset(reset), .btn_in(btn),
    .pulse_out(pulse_o[1]), .long_press(long_o[1]), .held(held_o[1]));
  pulse_gen_multi #(.N_CH(4), .MODE(2), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(4), .DB_CYCLES(DB)) dut2 (
    .clock(clock), .reset(reset), .btn_in(btn),
    .pulse_out(pulse_o[2]), .long_press(long_o[2]), .held(held_o[2]));
  pulse_gen_multi #(.N_CH(4), .MODE(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(0), .DB_CYCLES(DB)) dut3 (
    .clock(clock), .reset(reset), .btn_in(btn),
    .pulse_out(pulse_o[3]), .long_press(long_o[3]), .held(held_o[3]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Reference model: per channel, armed flag, previous level and length of the current armed press.
  bit         m_armed [4];
  bit         m_prev  [4];
  bit         m_filt  [4];
  int         m_len   [4];
  int         m_run   [4];
  logic [3:0] exp_pulse [NI];
  logic [3:0] exp_long;
  logic [3:0] exp_held;

  task automatic model_step(input logic [3:0] b_raw, input logic r);
    for (int ch = 0; ch < 4; ch++) begin
      bit b, act, rise, fall, rep, ev;
      if (r) begin
        m_armed[ch] = !b_raw[ch];
        m_prev[ch]  = b_raw[ch];
        m_filt[ch]  = b_raw[ch];
        m_run[ch]   = 0;
        m_len[ch]   = 0;
        exp_long[ch] = 1'b0;
        exp_held[ch] = 1'b0;
        for (int i = 0; i < NI; i++) exp_pulse[i][ch] = 1'b0;
      end else begin
`ifdef PULSE_GEN_DEBOUNCE_EN
        b = m_filt[ch];
        if (b_raw[ch] != m_filt[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DB) begin
            m_filt[ch] = b_raw[ch];
            m_run[ch]  = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
`else
        b = b_raw[ch];
`endif
        act  = m_armed[ch] && b;
        rise = m_armed[ch] && b && !m_prev[ch];
        fall = m_armed[ch] && !b && m_prev[ch];
        m_len[ch] = act ? m_len[ch] + 1 : 0;
        exp_long[ch] = act && (m_len[ch] == HOLD);
        exp_held[ch] = act;
        for (int i = 0; i < NI; i++) begin
          rep = (REP_CFG[i] > 0) && act && (m_len[ch] > HOLD) &&
                (((m_len[ch] - HOLD) % REP_CFG[i]) == 0);
          ev  = (MODE_CFG[i] == 0) ? rise : (MODE_CFG[i] == 1) ? fall : (rise || fall);
          exp_pulse[i][ch] = ev || rep;
        end
        m_armed[ch] = m_armed[ch] || !b;
        m_prev[ch]  = b;
      end
    end
  endtask

  // Apply inputs for one clock, advance the model, then compare on the falling edge.
  task automatic cycle(input logic [3:0] b, input logic r);
    btn   = b;
    reset = r;
    model_step(b, r);
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("pulse_out[u%0d]@%0t", i, $time), 32'(pulse_o[i]), 32'(exp_pulse[i]));
      check($sformatf("long_press[u%0d]@%0t", i, $time), 32'(long_o[i]), 32'(exp_long));
      check($sformatf("held[u%0d]@%0t", i, $time), 32'(held_o[i]), 32'(exp_held));
    end
  endtask

  task automatic hold_for(input logic [3:0] b, input logic r, input int n);
    for (int k = 0; k < n; k++) cycle(b, r);
  endtask

  int         dur [4];
  logic [3:0] rb;

  initial begin
    btn   = '0;
    reset = 1'b1;

    // Reset state, then a short press that never reaches long_press.
    hold_for(4'b0000, 1'b1, 2);
    hold_for(4'b0000, 1'b0, 3);
    hold_for(4'b0001, 1'b0, 3);
    hold_for(4'b0000, 1'b0, 8);

    // Channel 1 held through reset: silent until released and pressed again.
    hold_for(4'b0010, 1'b1, 2);
    hold_for(4'b0010, 1'b0, 12);
    hold_for(4'b0000, 1'b0, 2);
    hold_for(4'b0010, 1'b0, 2);
    hold_for(4'b0000, 1'b0, 8);

    // Long press with auto-repeat, then release.
    hold_for(4'b0001, 1'b0, 30);
    hold_for(4'b0000, 1'b0, 8);

    // Release landing on a repeat wrap: 15- and 11-sample presses.
    hold_for(4'b1100, 1'b0, 11);
    hold_for(4'b0100, 1'b0, 4);
    hold_for(4'b0000, 1'b0, 8);

    // Reset in the middle of a hold, keep holding, then release and re-press.
    hold_for(4'b0010, 1'b0, 6);
    hold_for(4'b0010, 1'b1, 1);
    hold_for(4'b0010, 1'b0, 14);
    hold_for(4'b0000, 1'b0, 2);
    hold_for(4'b0010, 1'b0, 12);
    hold_for(4'b0000, 1'b0, 8);

    // Random presses of mixed length, short glitches included, with rare resets.
    rb = 4'b0000;
    for (int ch = 0; ch < 4; ch++) dur[ch] = $urandom_range(1, 20);
    for (int k = 0; k < 4000; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (dur[ch] == 0) begin
          rb[ch]  = ~rb[ch];
          dur[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
        end
        dur[ch]--;
      end
      cycle(rb, ($urandom_range(0, 399) == 0));
    end
    hold_for(4'b0000, 1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
